// File: rtl/im2col_tensor_addr_pkg.sv
// Shared widths and beat-flag type for the im2col address generator.
package im2col_tensor_addr_pkg;
  localparam int T_W_DEF = 8;
  localparam int K_W_DEF = 4;
  localparam int C_W_DEF = 8;
  localparam int S_W_DEF = 4;
  localparam int A_W_DEF = 16;
  localparam int S2P_DEF = 8;

  typedef struct packed {
    logic pad;
    logic grp_last;
    logic patch_last;
    logic frame_last;
  } beat_flags_t;
endpackage

// File: rtl/im2col_tensor_addr_patch_cnt.sv
// Nested kc/kr/c/e patch counter; exposes next-state values so the top can
// register its outputs from them without a bubble.
module im2col_patch_cnt #(
  parameter int K_W = 4,
  parameter int C_W = 8,
  parameter int S2P = 8,
  parameter int LG  = $clog2(S2P),
  parameter int E_W = 2*K_W + C_W + LG
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 adv,
  input  logic [K_W-1:0]       k,
  input  logic [C_W-1:0]       ch,
  input  logic [2*K_W+C_W-1:0] brn,
  output logic [K_W-1:0]       kc_n,
  output logic [E_W-1:0]       e_n,
  output logic                 pad_n,
  output logic                 last_n,
  output logic                 row_step,
  output logic                 ch_step,
  output logic                 patch_wrap
);
  logic [K_W-1:0] kc, kr, kr_n, k_m1;
  logic [C_W-1:0] c, c_n, c_m1;
  logic [E_W-1:0] e, last_e;
  logic           pad, e_last;

  assign k_m1   = k - 1'b1;
  assign c_m1   = ch - 1'b1;
  assign last_e = (E_W'(brn) << LG) - E_W'(1);
  assign e_last = (e == last_e);
  assign last_n = (e_n == last_e);

  always_comb begin
    kc_n = kc; kr_n = kr; c_n = c; e_n = e; pad_n = pad;
    row_step = 1'b0; ch_step = 1'b0; patch_wrap = 1'b0;
    if (clr) begin
      kc_n = '0; kr_n = '0; c_n = '0; e_n = '0; pad_n = 1'b0;
    end else if (adv) begin
      if (e_last) begin
        kc_n = '0; kr_n = '0; c_n = '0; e_n = '0; pad_n = 1'b0;
        patch_wrap = 1'b1;
      end else begin
        e_n = e + 1'b1;
        // once the last real element is passed, kc/kr/c freeze until the patch wraps
        if (!pad) begin
          if (kc != k_m1) kc_n = kc + 1'b1;
          else if (kr != k_m1) begin
            kc_n = '0; kr_n = kr + 1'b1; row_step = 1'b1;
          end else if (c != c_m1) begin
            kc_n = '0; kr_n = '0; c_n = c + 1'b1; ch_step = 1'b1;
          end else pad_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kc <= '0; kr <= '0; c <= '0; e <= '0; pad <= 1'b0;
    end else begin
      kc <= kc_n; kr <= kr_n; c <= c_n; e <= e_n; pad <= pad_n;
    end
  end
endmodule

// File: rtl/im2col_tensor_addr.sv
// Im2col read-address generator: walks output positions and patch elements,
// emitting one registered tensor address per beat over valid/ready.
module im2col_tensor_addr
  import im2col_tensor_addr_pkg::*;
#(
  parameter int T_W = T_W_DEF,
  parameter int K_W = K_W_DEF,
  parameter int C_W = C_W_DEF,
  parameter int S_W = S_W_DEF,
  parameter int A_W = A_W_DEF,
  parameter int S2P = S2P_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic [T_W-1:0]       tensor_size,
  input  logic [K_W-1:0]       kernel_size,
  input  logic [C_W-1:0]       channels,
  input  logic [S_W-1:0]       stride,
  input  logic [T_W-1:0]       ofs,
  input  logic [2*K_W+C_W-1:0] brn,
  output logic                 addr_valid,
  input  logic                 addr_ready,
  output logic [A_W-1:0]       addr,
  output logic                 addr_pad,
  output logic                 grp_last,
  output logic                 patch_last,
  output logic                 frame_last,
  output logic                 busy,
  output logic                 done
);
  localparam int LG  = $clog2(S2P);
  localparam int B_W = 2*K_W + C_W;
  localparam int E_W = B_W + LG;
  localparam logic [E_W-1:0] GRP_M = E_W'(S2P - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;
  state_e state, state_n;

  logic [K_W-1:0] k_q;
  logic [C_W-1:0] c_q;
  logic [T_W-1:0] ofs_q, ofs_e;
  logic [B_W-1:0] brn_q, brn_e;
  logic [A_W-1:0] t_q, s_q, tt_q, st_q;
  logic [T_W-1:0] ow, oh, ow_n, oh_n;
  logic [A_W-1:0] colacc, rowacc, cbase, rbase, colacc_n, rowacc_n, cbase_n, rbase_n, sum;
  logic [A_W-1:0] addr_q;
  beat_flags_t    flags_q, flags_n;
  logic           valid_q, valid_n, acc, clr, adv, ld;

  logic [K_W-1:0] kc_n;
  logic [E_W-1:0] e_n;
  logic           pad_n, last_n, row_step, ch_step, patch_wrap;

  // in LOAD the first beat's flags are formed before the latches settle
  assign ofs_e = (state == S_LOAD) ? ofs : ofs_q;
  assign brn_e = (state == S_LOAD) ? brn : brn_q;
  assign acc   = valid_q & addr_ready;

  im2col_patch_cnt #(.K_W(K_W), .C_W(C_W), .S2P(S2P)) u_cnt (
    .clk(clk), .rstn(rstn), .clr(clr), .adv(adv),
    .k(k_q), .ch(c_q), .brn(brn_e),
    .kc_n(kc_n), .e_n(e_n), .pad_n(pad_n), .last_n(last_n),
    .row_step(row_step), .ch_step(ch_step), .patch_wrap(patch_wrap)
  );

  always_comb begin
    state_n = state; valid_n = valid_q;
    clr = 1'b0; adv = 1'b0; ld = 1'b0;
    case (state)
      S_IDLE: if (enable) state_n = S_LOAD;
      S_LOAD: begin
        clr = 1'b1;
        if (kernel_size == '0 || channels == '0 || brn == '0) begin
          state_n = S_DONE; valid_n = 1'b0;
        end else begin
          state_n = S_RUN; valid_n = 1'b1; ld = 1'b1;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_n = S_IDLE; valid_n = 1'b0;
        end else if (acc) begin
          if (flags_q.frame_last) begin
            state_n = S_DONE; valid_n = 1'b0;
          end else begin
            adv = 1'b1; ld = 1'b1;
          end
        end
      end
      S_DONE: begin
        valid_n = 1'b0;
        if (!enable) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ow_n = ow; oh_n = oh; colacc_n = colacc; rowacc_n = rowacc;
    cbase_n = cbase; rbase_n = rbase;
    if (clr) begin
      ow_n = '0; oh_n = '0; colacc_n = '0; rowacc_n = '0; cbase_n = '0; rbase_n = '0;
    end else begin
      if (patch_wrap) begin
        cbase_n = '0; rbase_n = '0;
        if (ow == ofs_q) begin
          ow_n = '0; colacc_n = '0; oh_n = oh + 1'b1; rowacc_n = rowacc + st_q;
        end else begin
          ow_n = ow + 1'b1; colacc_n = colacc + s_q;
        end
      end
      if (ch_step) begin
        cbase_n = cbase + tt_q; rbase_n = '0;
      end
      if (row_step) rbase_n = rbase + t_q;
    end
    sum = rowacc_n + colacc_n + cbase_n + rbase_n + A_W'(kc_n);
    flags_n.pad        = pad_n;
    flags_n.grp_last   = ((e_n & GRP_M) == GRP_M);
    flags_n.patch_last = last_n;
    flags_n.frame_last = last_n & (ow_n == ofs_e) & (oh_n == ofs_e);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE; valid_q <= 1'b0; addr_q <= '0; flags_q <= '0;
      k_q <= '0; c_q <= '0; ofs_q <= '0; brn_q <= '0;
      t_q <= '0; s_q <= '0; tt_q <= '0; st_q <= '0;
      ow <= '0; oh <= '0; colacc <= '0; rowacc <= '0; cbase <= '0; rbase <= '0;
    end else begin
      state <= state_n; valid_q <= valid_n;
      ow <= ow_n; oh <= oh_n; colacc <= colacc_n; rowacc <= rowacc_n;
      cbase <= cbase_n; rbase <= rbase_n;
      if (state == S_LOAD) begin
        k_q <= kernel_size; c_q <= channels; ofs_q <= ofs; brn_q <= brn;
        t_q <= A_W'(tensor_size); s_q <= A_W'(stride);
        tt_q <= A_W'(tensor_size) * A_W'(tensor_size);
        st_q <= A_W'(stride) * A_W'(tensor_size);
      end
      if (ld) begin
        addr_q <= flags_n.pad ? '0 : sum; flags_q <= flags_n;
      end else if (!valid_n) begin
        addr_q <= '0; flags_q <= '0;
      end
    end
  end

  assign addr_valid = valid_q;
  assign addr       = addr_q;
  assign addr_pad   = flags_q.pad;
  assign grp_last   = flags_q.grp_last;
  assign patch_last = flags_q.patch_last;
  assign frame_last = flags_q.frame_last;
  assign busy       = (state == S_LOAD) || (state == S_RUN);
  assign done       = (state == S_DONE);
endmodule

// File: tb/tb_im2col_tensor_addr.sv
// Scoreboard bench for im2col_tensor_addr: a loop-nest model fills the expected
// queue, observed beats are popped and checked on each handshake.
module tb_im2col_tensor_addr;
  logic        clk = 1'b0, rstn = 1'b0, enable = 1'b0, addr_ready = 1'b0;
  logic [7:0]  tensor_size = '0, channels = '0, ofs = '0;
  logic [3:0]  kernel_size = '0, stride = '0;
  logic [15:0] brn = '0;

  logic        v16, p16, g16, pl16, fl16, busy16, done16;
  logic [15:0] a16;
  logic        v8, p8, g8, pl8, fl8, busy8, done8;
  logic [7:0]  a8;

  typedef struct packed {
    logic [15:0] addr;
    logic pad, gl, pl, fl;
  } beat_t;

  bit    sel8 = 1'b0;
  beat_t obs_beat;
  logic  obs_valid, obs_busy, obs_done;
  beat_t q[$];
  int    total = 0, bad = 0;

  always #5 clk = ~clk;

  im2col_tensor_addr dut (
    .clk(clk), .rstn(rstn), .enable(enable), .tensor_size(tensor_size),
    .kernel_size(kernel_size), .channels(channels), .stride(stride), .ofs(ofs), .brn(brn),
    .addr_valid(v16), .addr_ready(addr_ready), .addr(a16), .addr_pad(p16), .grp_last(g16),
    .patch_last(pl16), .frame_last(fl16), .busy(busy16), .done(done16)
  );

  im2col_tensor_addr #(.A_W(8)) dut8 (
    .clk(clk), .rstn(rstn), .enable(enable), .tensor_size(tensor_size),
    .kernel_size(kernel_size), .channels(channels), .stride(stride), .ofs(ofs), .brn(brn),
    .addr_valid(v8), .addr_ready(addr_ready), .addr(a8), .addr_pad(p8), .grp_last(g8),
    .patch_last(pl8), .frame_last(fl8), .busy(busy8), .done(done8)
  );

  assign obs_beat  = sel8 ? {8'h00, a8, p8, g8, pl8, fl8} : {a16, p16, g16, pl16, fl16};
  assign obs_valid = sel8 ? v8 : v16;
  assign obs_busy  = sel8 ? busy8 : busy16;
  assign obs_done  = sel8 ? done8 : done16;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic build(input int t, k, s, c, o, b, aw);
    int kk, n, a, ci, kr, kc;
    kk = k * k * c;
    n  = b * 8;
    for (int oh = 0; oh <= o; oh++)
      for (int ow = 0; ow <= o; ow++)
        for (int e = 0; e < n; e++) begin
          beat_t x;
          a = 0;
          if (e < kk) begin
            ci = e / (k * k); kr = (e / k) % k; kc = e % k;
            a  = ci * t * t + (oh * s + kr) * t + ow * s + kc;
          end
          x.addr = 16'(a & ((1 << aw) - 1));
          x.pad  = (e >= kk);
          x.gl   = (e % 8) == 7;
          x.pl   = (e == n - 1);
          x.fl   = x.pl && ow == o && oh == o;
          q.push_back(x);
        end
  endtask

  // stall_at/abort_at are 0-based beat indices, -1 disables
  task automatic run_frame(input int t, k, s, c, o, b, stall_at, abort_at, input bit use_rst);
    int n = 0, exp_n, stall = 0, cyc = 0;
    bit fin = 0;
    beat_t x;
    q.delete();
    build(t, k, s, c, o, b, sel8 ? 8 : 16);
    exp_n = q.size();
    @(negedge clk);
    tensor_size = 8'(t); kernel_size = 4'(k); stride = 4'(s); channels = 8'(c);
    ofs = 8'(o); brn = 16'(b); enable = 1'b1; addr_ready = 1'b1;
    while (!fin && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (abort_at >= 0 && n == abort_at) begin
        if (use_rst) begin
          #1 rstn = 1'b0;
          #1 chk("rst_outs", {obs_valid, obs_beat, obs_busy, obs_done}, '0);
          @(negedge clk); enable = 1'b0; rstn = 1'b1;
        end else begin
          enable = 1'b0;
          @(negedge clk);
          chk("abort_valid_busy", {obs_valid, obs_busy}, '0);
        end
        return;
      end
      if (stall_at >= 0 && n == stall_at && stall < 3 && obs_valid && q.size() > 0) begin
        addr_ready = 1'b0; stall++;
        chk("stall_hold", {obs_valid, obs_beat}, {1'b1, q[0]});
      end else begin
        addr_ready = 1'b1;
        if (obs_valid) begin
          if (q.size() == 0) chk("overrun", n, exp_n);
          else begin
            x = q.pop_front();
            chk("beat", obs_beat, x);
            n++;
            if (x.fl) fin = 1;
          end
        end
      end
    end
    chk("frame_complete", fin, 1);
    chk("beat_count", n, exp_n);
    @(negedge clk);
    chk("done_after", {obs_done, obs_valid}, 2'b10);
    enable = 1'b0;
    @(negedge clk);
    chk("idle_after", {obs_done, obs_busy}, '0);
  endtask

  initial begin
    #2 chk("reset_outs", {v16, a16, p16, g16, pl16, fl16, busy16, done16}, '0);
    @(negedge clk); rstn = 1'b1;

    // basic frame, strided frame, multi-channel frame with no padding
    run_frame(4, 3, 1, 1, 1, 2, -1, -1, 0);
    run_frame(5, 3, 2, 1, 1, 2, -1, -1, 0);
    run_frame(4, 2, 1, 2, 2, 1, -1, -1, 0);
    // backpressure on the fifth beat (addr 5)
    run_frame(4, 3, 1, 1, 1, 2, 4, -1, 0);
    // abort via enable, then a full restart
    run_frame(4, 3, 1, 1, 1, 2, -1, 20, 0);
    run_frame(4, 3, 1, 1, 1, 2, -1, -1, 0);
    // abort via async reset, then a full restart
    run_frame(4, 3, 1, 1, 1, 2, -1, 20, 1);
    run_frame(4, 3, 1, 1, 1, 2, -1, -1, 0);

    // channels=0: no beats, done two edges after enable
    @(negedge clk);
    tensor_size = 8'd4; kernel_size = 4'd3; channels = 8'd0; stride = 4'd1;
    ofs = 8'd1; brn = 16'd2; enable = 1'b1;
    @(negedge clk); chk("degen_load", {obs_busy, obs_done, obs_valid}, 3'b100);
    @(negedge clk); chk("degen_done", {obs_busy, obs_done, obs_valid}, 3'b010);
    @(negedge clk); chk("degen_hold", {obs_done, obs_valid}, 2'b10);
    enable = 1'b0;

    // address wrap on the 8-bit instance
    sel8 = 1'b1;
    run_frame(255, 1, 1, 1, 1, 1, -1, -1, 0);
    sel8 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
